fifo_uart_tx: RTL

Drain stage placed directly downstream of the 8-deep `sync_fifo`. It pops one byte at a time from the FIFO read port and shifts it out as a UART 8N1 frame on a single serial line. It accounts for the FIFO's one-cycle registered read latency and never pops while a frame is in flight.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/bit_timer.sv | 36 +++
 rtl/sync_fifo.sv | 78 +++++++
 rtl/fifo_uart_tx.sv | 127 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, data width and stop-bit count.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    localparam int UART_DATA_W    = 8;
    localparam int UART_STOP_BITS = 1;
    localparam int UART_IDX_W     = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        CAPT  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } uart_state_e;

    // States whose duration is paced by the bit timer.
    function automatic logic state_is_timed(input uart_state_e s);
        return (s == START) || (s == DATA) || (s == STOP);
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, tick high on the last cycle of each period.
// Latency: tick is a pure decode of the counter register; clr takes effect on the next edge.
// Backpressure: none; clr holds the count at zero for as long as it is asserted.
// Ports: clk, rst (async active-low), clr (synchronous restart), tick (end of bit period).
module bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_LAST);

    // Explicit wrap on tick keeps non-power-of-two periods exact.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with a registered read port (data_out valid the cycle after rd).
// Latency: one cycle from rd to data_out; writes visible to count/empty one cycle later.
// Backpressure: writes while full and reads while empty are ignored; simultaneous wr+rd keeps count.
// Ports: clk, rst (async active-low), wr/din write port, rd/data_out read port, empty/full/count status.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic [W-1:0]               din,
    input  logic                       rd,
    output logic [W-1:0]               data_out,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  dout_q, dout_d;
    logic          wr_en, rd_en;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_FULL);
    assign count    = count_q;
    assign data_out = dout_q;
    assign wr_en    = wr && !full;
    assign rd_en    = rd && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = dout_q;
        if (wr_en) begin
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
        end
        if (rd_en) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
            dout_d = mem_q[rptr_q];
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; only pointers and count define occupancy.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte per frame from sync_fifo and shifts it out as UART 8N1.
// Latency: first start-bit cycle 3 cycles after the IDLE decision; frame 10*CLKS_PER_BIT cycles.
// Backpressure: pops only in IDLE with enable && !empty; never pops while a frame is in flight.
// Ports: clk, rst (async active-low), enable, empty, fifo_data in; rd, tx, busy, tx_done out.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   empty,
    input  logic [UART_DATA_W-1:0] fifo_data,
    output logic                   rd,
    output logic                   tx,
    output logic                   busy,
    output logic                   tx_done
);
    localparam logic [UART_IDX_W-1:0] DATA_LAST = UART_IDX_W'(UART_DATA_W - 1);
    localparam logic [UART_IDX_W-1:0] STOP_LAST = UART_IDX_W'(UART_STOP_BITS - 1);

    uart_state_e            state_q, state_d;
    logic [UART_DATA_W-1:0] shreg_q, shreg_d;
    logic [UART_IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;
    logic                   tick;
    logic                   timer_clr;

    // Restart the bit period on every state change and park it outside the timed states.
    assign timer_clr = (state_d != state_q) || !state_is_timed(state_q);

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !empty) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = CAPT;
            end
            CAPT: begin
                // fifo_data became valid at the end of the POP cycle.
                shreg_d = fifo_data;
                state_d = START;
            end
            START: begin
                if (tick) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == DATA_LAST) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_idx_q == STOP_LAST) begin
                        bit_idx_d = '0;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state so the registered tx lines up with state_q.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign rd      = (state_q == POP);
    assign busy    = (state_q != IDLE);
    assign tx      = tx_q;
    assign tx_done = done_q;

endmodule
